pll_phase_ctrl: RTL and testbench



---
 rtl/pll_phase_ctrl_pkg.sv | 33 +++
 rtl/pll_phase_ctrl_sync2.sv | 26 ++
 rtl/pll_phase_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and pin constants for the ECP5 EHXPLLL dynamic phase sequencer.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        LOCKWAIT,
        DONE
    } state_t;

    localparam logic [1:0] PHASESEL_CLKOP  = 2'd0;
    localparam logic [1:0] PHASESEL_CLKOS  = 2'd1;
    localparam logic [1:0] PHASESEL_CLKOS2 = 2'd2;
    localparam logic [1:0] PHASESEL_CLKOS3 = 2'd3;

    localparam logic PHASESTEP_IDLE    = 1'b1;
    localparam logic PHASEDIR_IDLE     = 1'b1;
    localparam logic PHASELOADREG_IDLE = 1'b1;

    function automatic logic [1:0] sel_enc(input logic [1:0] sel);
        logic [1:0] enc;
        case (sel)
            2'd0:    enc = PHASESEL_CLKOP;
            2'd1:    enc = PHASESEL_CLKOS;
            2'd2:    enc = PHASESEL_CLKOS2;
            default: enc = PHASESEL_CLKOS3;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_sync2.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP for one phase-adjust request at a time,
// then waits for the PLL to re-lock and reports completion or timeout.
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int STEP_W    = 8,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8,
    parameter int LOCK_TMO  = 65535,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              busy,
    input  logic              locked,
    output logic              lock_lost,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TMO - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic              lost_q, lost_d;
    logic              lock_prev_q;
    logic              lock_s;
    logic              accept;

    sync2 #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (locked),
        .q_o   (lock_s)
    );

    assign accept       = req_valid & req_ready;
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_err      = (state_q == DONE) & err_q;
    assign lock_lost    = lost_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = PHASELOADREG_IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;
        lost_d  = lost_q;

        // Lock dropping mid-request is expected; only flag it while parked.
        if (accept)
            lost_d = 1'b0;
        else if (state_q == IDLE && lock_prev_q && !lock_s)
            lost_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (req_steps == '0) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_enc(req_sel);
                        dir_d   = req_dir;
                        rem_d   = req_steps;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    rem_d   = rem_q - STEP_W'(1);
                    state_d = (rem_q == STEP_W'(1)) ? LOCKWAIT : GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOCKWAIT: begin
                if (lock_s) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered from next state so the pin is low exactly while in PULSE.
        step_d = (state_d != PULSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            sel_q       <= PHASESEL_CLKOP;
            dir_q       <= PHASEDIR_IDLE;
            step_q      <= PHASESTEP_IDLE;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            lock_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            lock_prev_q <= lock_s;
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: expected responses queued at request time,
// checked when rsp_valid appears; pulse shape monitored every cycle.
module tb_pll_phase_ctrl;

    localparam int STEP_W = 8;
    localparam int SETUP  = 4;
    localparam int PULSE  = 4;
    localparam int GAP    = 8;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_sel;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;
    logic              rsp_valid;
    logic              rsp_err;
    logic              busy;
    logic              locked;
    logic              lock_lost;
    logic [1:0]        phasesel;
    logic              phasedir;
    logic              phasestep;
    logic              phaseloadreg;

    pll_phase_ctrl #(
        .STEP_W(STEP_W), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
        .GAP_CYC(GAP), .LOCK_TMO(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy),
        .locked(locked), .lock_lost(lock_lost),
        .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   falls   = 0;
    int   lo_len  = 0;
    int   hi_len  = 0;
    int   acc_cyc = 0;
    logic prev_step = 1'b1;
    logic gap_armed = 1'b0;
    logic trunc_ok  = 1'b0;
    logic [1:0] exp_sel = 2'd0;
    logic exp_dir = 1'b1;

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rsp_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp: got cycle %0d err %b, required cycle %0d err %b",
                             cyc, rsp_err, e.cyc, e.err);
                end
            end
            n_tests++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_done: req_ready=%b, required 0", req_ready);
            end
        end
        if (phasestep === 1'b0) begin
            if (prev_step) begin
                falls++;
                if (gap_armed) begin
                    n_tests++;
                    if (hi_len != GAP) begin
                        n_fail++;
                        $display("FAIL gap_width: %0d cycles high, required %0d", hi_len, GAP);
                    end
                end
                lo_len = 1;
            end else begin
                lo_len++;
            end
            n_tests++;
            if (phasesel !== exp_sel || phasedir !== exp_dir) begin
                n_fail++;
                $display("FAIL sel_dir: phasesel=%0d phasedir=%b, required %0d %b",
                         phasesel, phasedir, exp_sel, exp_dir);
            end
        end else begin
            if (!prev_step) begin
                if (!trunc_ok) begin
                    n_tests++;
                    if (lo_len != PULSE) begin
                        n_fail++;
                        $display("FAIL pulse_width: %0d cycles low, required %0d", lo_len, PULSE);
                    end
                end
                trunc_ok  = 1'b0;
                gap_armed = 1'b1;
                hi_len    = 1;
            end else begin
                hi_len++;
            end
        end
        prev_step = (phasestep === 1'b0) ? 1'b0 : 1'b1;
    endtask

    // Drives one request for a single cycle; w = LOCKWAIT cycles expected.
    task automatic send(input logic [1:0] sel, input logic dir, input logic [STEP_W-1:0] steps,
                        input int w, input logic err, input logic push);
        exp_t e;
        int   lat;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready: %b before request, required 1", req_ready);
        end
        acc_cyc   = cyc;
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        exp_sel   = sel;
        exp_dir   = dir;
        gap_armed = 1'b0;
        if (steps == '0)
            lat = 1;
        else
            lat = 1 + SETUP + int'(steps) * PULSE + (int'(steps) - 1) * GAP + w;
        if (push) begin
            e.cyc = acc_cyc + lat;
            e.err = err;
            exp_q.push_back(e);
        end
        tick();
        req_valid = 1'b0;
        req_sel   = ~sel;
        req_dir   = ~dir;
        req_steps = steps + 8'd3;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        req_dir   = 1'b0;
        req_steps = '0;
        locked    = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({req_ready, busy, rsp_valid, rsp_err, lock_lost, phasesel, phasedir, phasestep, phaseloadreg}
            !== 10'b1_0_0_0_0_00_1_1_1) begin
            n_fail++;
            $display("FAIL reset_in: outputs %b, required 1000000111",
                     {req_ready, busy, rsp_valid, rsp_err, lock_lost, phasesel, phasedir, phasestep, phaseloadreg});
        end
        reset = 1'b0;
        repeat (4) tick();
        n_tests++;
        if ({req_ready, busy, rsp_valid, rsp_err, lock_lost, phasesel, phasedir, phasestep, phaseloadreg}
            !== 10'b1_0_0_0_0_00_1_1_1) begin
            n_fail++;
            $display("FAIL reset_out: outputs %b, required 1000000111",
                     {req_ready, busy, rsp_valid, rsp_err, lock_lost, phasesel, phasedir, phasestep, phaseloadreg});
        end
    endtask

    task automatic test_steps3();
        int f0;
        f0 = falls;
        send(2'd2, 1'b0, 8'd3, 1, 1'b0, 1'b1);
        wait_done("steps3", 200);
        n_tests++;
        if (falls - f0 != 3) begin
            n_fail++;
            $display("FAIL steps3_falls: %0d falling edges, required 3", falls - f0);
        end
        n_tests++;
        if (phaseloadreg !== 1'b1) begin
            n_fail++;
            $display("FAIL loadreg: phaseloadreg=%b, required 1", phaseloadreg);
        end
        repeat (2) tick();
    endtask

    task automatic test_zero_steps();
        int f0;
        f0 = falls;
        send(2'd1, 1'b1, 8'd0, 0, 1'b0, 1'b1);
        wait_done("zero", 20);
        repeat (3) tick();
        n_tests++;
        if (falls != f0) begin
            n_fail++;
            $display("FAIL zero_falls: %0d falling edges, required 0", falls - f0);
        end
    endtask

    task automatic test_timeout();
        locked = 1'b0;
        send(2'd3, 1'b1, 8'd1, TMO, 1'b1, 1'b1);
        wait_done("timeout", 300);
        n_tests++;
        if (lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_lost: lock_lost=%b, required 0", lock_lost);
        end
        locked = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_lock_drop();
        int f0;
        int n;
        f0 = falls;
        send(2'd1, 1'b1, 8'd2, 22, 1'b0, 1'b1);
        n = 0;
        while (falls == f0 && n < 50) begin
            tick();
            n++;
        end
        locked = 1'b0;
        n = 0;
        while (cyc < acc_cyc + 1 + SETUP + 2 * PULSE + GAP + 19 && n < 200) begin
            tick();
            n++;
        end
        locked = 1'b1;
        wait_done("lockdrop", 100);
        n_tests++;
        if (lock_lost !== 1'b0 || falls - f0 != 2) begin
            n_fail++;
            $display("FAIL lockdrop_state: lock_lost=%b falls=%0d, required 0 and 2", lock_lost, falls - f0);
        end
        repeat (3) tick();
    endtask

    task automatic test_lock_lost();
        logic [2:0] want;
        want = 3'b001;
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (lock_lost !== want[2-i]) begin
                n_fail++;
                $display("FAIL lock_lost_t%0d: lock_lost=%b, required %b", i + 1, lock_lost, want[2-i]);
            end
        end
        locked = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (lock_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_lost_sticky: lock_lost=%b, required 1", lock_lost);
        end
        send(2'd3, 1'b0, 8'd0, 0, 1'b0, 1'b1);
        n_tests++;
        if (lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_lost_clear: lock_lost=%b, required 0", lock_lost);
        end
        wait_done("lostclr", 20);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int f0;
        int n;
        f0 = falls;
        send(2'd0, 1'b1, 8'd5, 1, 1'b0, 1'b0);
        n = 0;
        while (falls < f0 + 2 && n < 100) begin
            tick();
            n++;
        end
        n_tests++;
        if (falls < f0 + 2) begin
            n_fail++;
            $display("FAIL rmid_reach: %0d pulses seen, required 2", falls - f0);
        end
        reset    = 1'b1;
        trunc_ok = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({phasestep, busy, req_ready, rsp_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL rmid_state: step/busy/ready/rsp=%b, required 1010",
                     {phasestep, busy, req_ready, rsp_valid});
        end
        repeat (6) tick();
        f0 = falls;
        send(2'd3, 1'b0, 8'd1, 1, 1'b0, 1'b1);
        wait_done("rmid_after", 50);
        n_tests++;
        if (falls - f0 != 1) begin
            n_fail++;
            $display("FAIL rmid_falls: %0d falling edges, required 1", falls - f0);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_steps3();
        test_zero_steps();
        test_timeout();
        test_lock_drop();
        test_lock_lost();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
